// File: rtl/hazard_fwd_pkg.sv
// Shared definitions for the forwarding / load-use hazard controller:
// datapath defaults and the EX operand-mux select encodings.
package hazard_fwd_pkg;

  localparam int DW_DEF = 16;  // datapath width
  localparam int RW_DEF = 4;   // register index width (x0..x15)

  typedef logic [1:0] sel_t;

  // Operand-mux select encodings; 2'b11 is never produced.
  localparam sel_t SEL_RF    = 2'b00;  // register file value
  localparam sel_t SEL_EXMEM = 2'b01;  // result sitting in EX/MEM
  localparam sel_t SEL_MEMWB = 2'b10;  // result sitting in MEM/WB

endpackage : hazard_fwd_pkg

// File: rtl/hazard_fwd_unit_hazard_cmp.sv
// Per-source hazard comparator: checks one decode source operand against
// the producer currently in EX and the producer held in EX/MEM, picks the
// forwarding select (younger producer wins) and flags a load-use hazard.
module hazard_cmp
  import hazard_fwd_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic          i_use,
  input  logic [RW-1:0] i_rs,
  input  logic          i_ex_valid,
  input  logic          i_ex_we,
  input  logic          i_ex_load,
  input  logic [RW-1:0] i_ex_rd,
  input  logic          i_exmem_valid,
  input  logic          i_exmem_we,
  input  logic [RW-1:0] i_exmem_rd,
  output sel_t          o_sel,
  output logic          o_load_use
);

  logic w_hit_ex;
  logic w_hit_exmem;

  // A producer only matters if it really writes a non-zero register that
  // this source actually reads; x0 is hard-wired zero and never forwarded.
  assign w_hit_ex    = i_ex_valid & i_ex_we & (i_ex_rd != '0) &
                       i_use & (i_rs == i_ex_rd);
  assign w_hit_exmem = i_exmem_valid & i_exmem_we & (i_exmem_rd != '0) &
                       i_use & (i_rs == i_exmem_rd);

  // Priority select: the EX producer is younger, so it shadows EX/MEM.
  always_comb begin
    // NOTE: o_sel gets a default before any branch so no latch is inferred.
    o_sel = SEL_RF;
    if (w_hit_ex) begin
      o_sel = SEL_EXMEM;
    end else if (w_hit_exmem) begin
      o_sel = SEL_MEMWB;
    end
  end

  // A load in EX has no data until MEM, so its consumer must wait a cycle.
  assign o_load_use = w_hit_ex & i_ex_load;

endmodule : hazard_cmp

// File: rtl/hazard_fwd_unit.sv
// Forwarding and load-use hazard controller for the 16-bit pipeline.
// Owns the EX/MEM and MEM/WB result registers, registers the EX operand-mux
// selects one cycle ahead of the consumer's EX cycle, stalls decode on
// load-use and drives the register-file write-back port.
module hazard_fwd_unit
  import hazard_fwd_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  // decode slot
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_use1,
  input  logic          id_use2,
  input  logic          flush,
  // EX stage
  input  logic          ex_valid,
  input  logic          ex_we,
  input  logic          ex_load,
  input  logic [RW-1:0] ex_rd,
  input  logic [DW-1:0] ex_y,
  // data memory read data for the instruction in EX/MEM
  input  logic [DW-1:0] mem_rdata,
  // EX operand muxes
  output logic [1:0]    sel_a,
  output logic [1:0]    sel_b,
  output logic [DW-1:0] fwd_exmem,
  output logic [DW-1:0] fwd_memwb,
  output logic          stall,
  // register-file write port
  output logic          wb_we,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data
);

  // EX/MEM result register
  logic          r_exmem_valid;
  logic          r_exmem_we;
  logic          r_exmem_load;
  logic [RW-1:0] r_exmem_rd;
  logic [DW-1:0] r_exmem_y;

  // MEM/WB result register
  logic          r_memwb_valid;
  logic          r_memwb_we;
  logic [RW-1:0] r_memwb_rd;
  logic [DW-1:0] r_memwb_data;

  // registered operand selects for the instruction now in EX
  sel_t          r_sel_a;
  sel_t          r_sel_b;

  sel_t          w_sel_a;
  sel_t          w_sel_b;
  logic          w_lu_a;
  logic          w_lu_b;
  logic          w_bubble;
  logic [DW-1:0] w_memwb_data_d;

  hazard_cmp #(.RW(RW)) u_cmp_rs1 (
    .i_use         (id_use1),
    .i_rs          (id_rs1),
    .i_ex_valid    (ex_valid),
    .i_ex_we       (ex_we),
    .i_ex_load     (ex_load),
    .i_ex_rd       (ex_rd),
    .i_exmem_valid (r_exmem_valid),
    .i_exmem_we    (r_exmem_we),
    .i_exmem_rd    (r_exmem_rd),
    .o_sel         (w_sel_a),
    .o_load_use    (w_lu_a)
  );

  hazard_cmp #(.RW(RW)) u_cmp_rs2 (
    .i_use         (id_use2),
    .i_rs          (id_rs2),
    .i_ex_valid    (ex_valid),
    .i_ex_we       (ex_we),
    .i_ex_load     (ex_load),
    .i_ex_rd       (ex_rd),
    .i_exmem_valid (r_exmem_valid),
    .i_exmem_we    (r_exmem_we),
    .i_exmem_rd    (r_exmem_rd),
    .o_sel         (w_sel_b),
    .o_load_use    (w_lu_b)
  );

  // Load-use stall; a flush kills the decode instruction so it never stalls.
  // Gated by rst_n so every output reads zero while reset is held.
  assign stall = rst_n & id_valid & ~flush & (w_lu_a | w_lu_b);

  // Both a stall and a flush send a bubble into EX, whose selects are 00.
  assign w_bubble = stall | flush;

  // Loads write back the memory read data, everything else the ALU result.
  assign w_memwb_data_d = r_exmem_load ? mem_rdata : r_exmem_y;

  // EX/MEM capture: never stalled, samples the EX stage every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; every register here, data included, is reset.
    if (!rst_n) begin
      r_exmem_valid <= 1'b0;
      r_exmem_we    <= 1'b0;
      r_exmem_load  <= 1'b0;
      r_exmem_rd    <= '0;
      r_exmem_y     <= '0;
    end else begin
      r_exmem_valid <= ex_valid;
      r_exmem_we    <= ex_we;
      r_exmem_load  <= ex_load;
      r_exmem_rd    <= ex_rd;
      r_exmem_y     <= ex_y;
    end
  end

  // MEM/WB capture: tags follow EX/MEM, data is the load-or-ALU result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memwb_valid <= 1'b0;
      r_memwb_we    <= 1'b0;
      r_memwb_rd    <= '0;
      r_memwb_data  <= '0;
    end else begin
      r_memwb_valid <= r_exmem_valid;
      r_memwb_we    <= r_exmem_we;
      r_memwb_rd    <= r_exmem_rd;
      r_memwb_data  <= w_memwb_data_d;
    end
  end

  // Decode-time selects registered so they line up with the EX cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_a <= SEL_RF;
      r_sel_b <= SEL_RF;
    end else if (w_bubble) begin
      r_sel_a <= SEL_RF;
      r_sel_b <= SEL_RF;
    end else begin
      r_sel_a <= w_sel_a;
      r_sel_b <= w_sel_b;
    end
  end

  assign sel_a     = r_sel_a;
  assign sel_b     = r_sel_b;
  assign fwd_exmem = r_exmem_y;
  assign fwd_memwb = r_memwb_data;

  // The register file is write-first, so no WB-to-decode bypass is needed.
  assign wb_we   = r_memwb_valid & r_memwb_we & (r_memwb_rd != '0);
  assign wb_rd   = r_memwb_rd;
  assign wb_data = r_memwb_data;

endmodule : hazard_fwd_unit

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: a table of two-cycle producer/consumer
// scenarios plus hand-written sequences for forwarding data, load-use,
// double producers, x0 write-back and asynchronous reset.
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use1, id_use2, flush;
  logic [3:0]  id_rs1, id_rs2;
  logic        ex_valid, ex_we, ex_load;
  logic [3:0]  ex_rd;
  logic [15:0] ex_y, mem_rdata;
  logic [1:0]  sel_a, sel_b;
  logic [15:0] fwd_exmem, fwd_memwb, wb_data;
  logic        stall, wb_we;
  logic [3:0]  wb_rd;

  int checks   = 0;
  int failures = 0;

  hazard_fwd_unit #(.DW(16), .RW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_use1   (id_use1),
    .id_use2   (id_use2),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .ex_we     (ex_we),
    .ex_load   (ex_load),
    .ex_rd     (ex_rd),
    .ex_y      (ex_y),
    .mem_rdata (mem_rdata),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .fwd_exmem (fwd_exmem),
    .fwd_memwb (fwd_memwb),
    .stall     (stall),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  // o_* = older producer (lands in EX/MEM), y_* = younger producer (in EX
  // while the consumer decodes), then consumer fields and expectations.
  typedef struct {
    string      name;
    logic       o_v, o_we, o_ld;
    logic [3:0] o_rd;
    logic       y_v, y_we, y_ld;
    logic [3:0] y_rd;
    logic [3:0] rs1, rs2;
    logic       u1, u2, fl;
    logic       e_stall;
    logic [1:0] e_sa, e_sb;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic we, input logic ld,
                        input logic [3:0] rd, input logic [15:0] y);
    ex_valid = v; ex_we = we; ex_load = ld; ex_rd = rd; ex_y = y;
  endtask

  task automatic set_id(input logic v, input logic [3:0] r1,
                        input logic [3:0] r2, input logic u1,
                        input logic u2, input logic fl);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use1 = u1; id_use2 = u2;
    flush = fl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{"alu_b2b",      1'b0,1'b0,1'b0,4'd0, 1'b1,1'b1,1'b0,4'd3, 4'd3,4'd4, 1'b1,1'b1,1'b0, 1'b0,2'b01,2'b00};
    vecs[1]  = '{"alu_dist2",    1'b1,1'b1,1'b0,4'd3, 1'b0,1'b0,1'b0,4'd0, 4'd1,4'd3, 1'b1,1'b1,1'b0, 1'b0,2'b00,2'b10};
    vecs[2]  = '{"both_x3",      1'b1,1'b1,1'b0,4'd3, 1'b1,1'b1,1'b0,4'd3, 4'd3,4'd3, 1'b1,1'b1,1'b0, 1'b0,2'b01,2'b01};
    vecs[3]  = '{"rd_x0",        1'b1,1'b1,1'b0,4'd0, 1'b1,1'b1,1'b1,4'd0, 4'd0,4'd0, 1'b1,1'b1,1'b0, 1'b0,2'b00,2'b00};
    vecs[4]  = '{"no_use",       1'b0,1'b0,1'b0,4'd0, 1'b1,1'b1,1'b1,4'd5, 4'd5,4'd5, 1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00};
    vecs[5]  = '{"we_zero",      1'b1,1'b0,1'b0,4'd7, 1'b1,1'b0,1'b0,4'd7, 4'd7,4'd7, 1'b1,1'b1,1'b0, 1'b0,2'b00,2'b00};
    vecs[6]  = '{"valid_zero",   1'b0,1'b1,1'b0,4'd7, 1'b0,1'b1,1'b1,4'd7, 4'd7,4'd7, 1'b1,1'b1,1'b0, 1'b0,2'b00,2'b00};
    vecs[7]  = '{"load_use_rs2", 1'b0,1'b0,1'b0,4'd0, 1'b1,1'b1,1'b1,4'd5, 4'd1,4'd5, 1'b1,1'b1,1'b0, 1'b1,2'b00,2'b00};
    vecs[8]  = '{"flush_lu",     1'b0,1'b0,1'b0,4'd0, 1'b1,1'b1,1'b1,4'd5, 4'd5,4'd5, 1'b1,1'b1,1'b1, 1'b0,2'b00,2'b00};
    vecs[9]  = '{"flush_alu",    1'b1,1'b1,1'b0,4'd4, 1'b1,1'b1,1'b0,4'd3, 4'd3,4'd4, 1'b1,1'b1,1'b1, 1'b0,2'b00,2'b00};
    vecs[10] = '{"load_dist2",   1'b1,1'b1,1'b1,4'd6, 1'b0,1'b0,1'b0,4'd0, 4'd6,4'd2, 1'b1,1'b1,1'b0, 1'b0,2'b10,2'b00};
    vecs[11] = '{"load_unused",  1'b0,1'b0,1'b0,4'd0, 1'b1,1'b1,1'b1,4'd5, 4'd5,4'd8, 1'b0,1'b1,1'b0, 1'b0,2'b00,2'b00};
    vecs[12] = '{"mixed",        1'b1,1'b1,1'b0,4'd2, 1'b1,1'b1,1'b0,4'd9, 4'd9,4'd2, 1'b1,1'b1,1'b0, 1'b0,2'b01,2'b10};

    // reset state
    rst_n = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    mem_rdata = 16'h0;
    #1;
    check("rst_sel_a", {14'd0, sel_a}, 16'h0);
    check("rst_sel_b", {14'd0, sel_b}, 16'h0);
    check("rst_stall", {15'd0, stall}, 16'h0);
    check("rst_wb_we", {15'd0, wb_we}, 16'h0);
    check("rst_fwd_exmem", fwd_exmem, 16'h0);
    check("rst_fwd_memwb", fwd_memwb, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // table: older producer, then younger producer with consumer in decode
    for (int i = 0; i < NV; i++) begin
      set_ex(vecs[i].o_v, vecs[i].o_we, vecs[i].o_ld, vecs[i].o_rd, 16'h1111);
      set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      tick();
      set_ex(vecs[i].y_v, vecs[i].y_we, vecs[i].y_ld, vecs[i].y_rd, 16'h2222);
      set_id(1'b1, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].fl);
      #2;
      check({vecs[i].name, "_stall"}, {15'd0, stall}, {15'd0, vecs[i].e_stall});
      tick();
      check({vecs[i].name, "_sel_a"}, {14'd0, sel_a}, {14'd0, vecs[i].e_sa});
      check({vecs[i].name, "_sel_b"}, {14'd0, sel_b}, {14'd0, vecs[i].e_sb});
    end

    // ALU to ALU forwarding with data and write-back
    set_ex(1'b1, 1'b1, 1'b0, 4'd3, 16'h1234);
    set_id(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0);
    #2;
    check("fwd_add_stall", {15'd0, stall}, 16'h0);
    tick();
    check("fwd_add_sel_a", {14'd0, sel_a}, 16'h1);
    check("fwd_add_exmem", fwd_exmem, 16'h1234);
    set_ex(1'b1, 1'b1, 1'b0, 4'd6, 16'h0777);
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("fwd_add_memwb", fwd_memwb, 16'h1234);
    check("fwd_add_wb_we", {15'd0, wb_we}, 16'h1);
    check("fwd_add_wb_rd", {12'd0, wb_rd}, 16'h3);
    check("fwd_add_wb_data", wb_data, 16'h1234);

    // load-use: lw x5 then add x6,x5,x5
    set_ex(1'b1, 1'b1, 1'b1, 4'd5, 16'h0040);
    set_id(1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0);
    #2;
    check("lu_stall1", {15'd0, stall}, 16'h1);
    tick();
    check("lu_bubble_sel_a", {14'd0, sel_a}, 16'h0);
    set_ex(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    mem_rdata = 16'hBEEF;
    #2;
    check("lu_stall2", {15'd0, stall}, 16'h0);
    tick();
    mem_rdata = 16'h0;
    check("lu_sel_a", {14'd0, sel_a}, 16'h2);
    check("lu_sel_b", {14'd0, sel_b}, 16'h2);
    check("lu_fwd_memwb", fwd_memwb, 16'hBEEF);
    check("lu_wb_rd", {12'd0, wb_rd}, 16'h5);
    check("lu_wb_we", {15'd0, wb_we}, 16'h1);

    // x3 written by both EX/MEM (value 1) and EX (value 2): younger wins
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    set_ex(1'b1, 1'b1, 1'b0, 4'd3, 16'h0001);
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 4'd3, 16'h0002);
    set_id(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("dbl_sel_a", {14'd0, sel_a}, 16'h1);
    check("dbl_operand", fwd_exmem, 16'h0002);
    check("dbl_memwb", fwd_memwb, 16'h0001);

    // reset asserted mid-stream with a pending load-use
    set_ex(1'b1, 1'b1, 1'b1, 4'd5, 16'h0050);
    set_id(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0);
    #2;
    check("pre_rst_stall", {15'd0, stall}, 16'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", {15'd0, stall}, 16'h0);
    check("mid_rst_sel_a", {14'd0, sel_a}, 16'h0);
    check("mid_rst_wb_we", {15'd0, wb_we}, 16'h0);
    check("mid_rst_wb_rd", {12'd0, wb_rd}, 16'h0);
    check("mid_rst_wb_data", wb_data, 16'h0);
    check("mid_rst_fwd_exmem", fwd_exmem, 16'h0);
    check("mid_rst_fwd_memwb", fwd_memwb, 16'h0);
    set_ex(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // write to x0 never reaches the register file
    set_ex(1'b1, 1'b1, 1'b0, 4'd0, 16'h0055);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    tick();
    check("x0_wb_we", {15'd0, wb_we}, 16'h0);
    check("x0_wb_data", wb_data, 16'h0055);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hazard_fwd_unit
